mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO.
//
// Runs MULT/MULTU/DIV/DIVU over WIDTH cycles. Multiplication uses
// shift-add and division uses restoring shift-subtract. Both share one
// accumulator/shift register pair, so HI/LO fall out of the same registers.
// MTHI/MTLO writes go straight into HI/LO when no operation is running.
//
// Optional feature macro: MULT_DIV_SIGNED_EN
//   defined   : op[1]=1 selects signed MULT/DIV. The datapath works on
//               magnitudes and the signs are fixed up on the final edge.
//   undefined : op[1] is ignored and every operation is unsigned.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start, op[1:0]    issue request; op 00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   operandA/B        rs / rt (multiplicand/dividend, multiplier/divisor)
//   mtWrite, mtSel,   MTLO (mtSel=0) / MTHI (mtSel=1) write strobe and data
//   mtData
//   busy              high while an operation is iterating
//   done              one-cycle pulse once HI/LO hold the new result
//   divByZero         pulses together with done for a zero divisor
//   hi, lo            architectural HI/LO registers
//   dbg_state         current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is taken on any rising edge where busy=0 (IDLE or DONE).
// While busy=1, start and mtWrite are ignored. If start and mtWrite arrive
// in the same accepted cycle, start wins and the write is dropped.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             mtWrite,
  input  logic             mtSel,
  input  logic [WIDTH-1:0] mtData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             dz;
  logic [WIDTH-1:0] acc;   // partial product high half / partial remainder
  logic [WIDTH-1:0] qr;    // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] bop;   // multiplicand / divisor magnitude

  logic accept;
  logic last;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------
  // Operand conditioning
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef MULT_DIV_SIGNED_EN
  logic sgn_a, sgn_b;
  logic neg_q, neg_r;   // neg_q also marks a negative product

  assign sgn_a = op[1] & operandA[WIDTH-1];
  assign sgn_b = op[1] & operandB[WIDTH-1];
  // The magnitude of the most negative value wraps to itself. As an
  // unsigned number it is still the correct magnitude.
  assign a_mag = sgn_a ? -operandA : operandA;
  assign b_mag = sgn_b ? -operandB : operandB;
`else
  logic unused_op1;
  assign unused_op1 = op[1];
  assign a_mag      = operandA;
  assign b_mag      = operandB;
`endif

  // ---------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   m_sum, d_shift, d_diff;
  logic [WIDTH-1:0] acc_nx, qr_nx;

  always_comb begin
    m_sum   = {1'b0, acc} + (qr[0] ? {1'b0, bop} : '0);
    d_shift = {acc, qr[WIDTH-1]};
    // The partial remainder stays below the divisor, so the top bit of
    // d_diff is set exactly when the trial subtraction borrows.
    d_diff  = d_shift - {1'b0, bop};
    if (is_div) begin
      if (!d_diff[WIDTH]) begin
        acc_nx = d_diff[WIDTH-1:0];
        qr_nx  = {qr[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = d_shift[WIDTH-1:0];
        qr_nx  = {qr[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx = m_sum[WIDTH:1];
      qr_nx  = {m_sum[0], qr[WIDTH-1:1]};
    end
  end

  // Final result: acc holds HI (product high / remainder), qr holds LO.
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    res_hi = acc_nx;
    res_lo = qr_nx;
`ifdef MULT_DIV_SIGNED_EN
    if (is_div) begin
      // A zero divisor leaves |A| in the remainder. Restoring the sign of A
      // then yields A itself, which is the required HI value.
      if (neg_r)        res_hi = -acc_nx;
      if (neg_q && !dz) res_lo = -qr_nx;
    end else if (neg_q) begin
      {res_hi, res_lo} = -{acc_nx, qr_nx};
    end
`endif
    if (dz) res_lo = '1;
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // Datapath and HI/LO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      is_div    <= 1'b0;
      dz        <= 1'b0;
      acc       <= '0;
      qr        <= '0;
      bop       <= '0;
      hi        <= '0;
      lo        <= '0;
      divByZero <= 1'b0;
`ifdef MULT_DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      divByZero <= 1'b0;
      if (accept) begin
        cnt    <= '0;
        is_div <= op[0];
        dz     <= op[0] && (operandB == '0);
        acc    <= '0;
        qr     <= a_mag;
        bop    <= b_mag;
`ifdef MULT_DIV_SIGNED_EN
        neg_q  <= sgn_a ^ sgn_b;
        neg_r  <= sgn_a;
`endif
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        acc <= acc_nx;
        qr  <= qr_nx;
        if (last) begin
          hi        <= res_hi;
          lo        <= res_lo;
          divByZero <= dz;
        end
      end else if (mtWrite) begin
        if (mtSel) hi <= mtData;
        else       lo <= mtData;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed cases plus randomized operations,
// checked against an arithmetic reference model and a queue of expected
// HI/LO/divByZero values.
module tb_mult_div_unit;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] operandA, operandB;
  logic         mtWrite, mtSel;
  logic [W-1:0] mtData;
  logic         busy, done, divByZero;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB),
    .mtWrite(mtWrite), .mtSel(mtSel), .mtData(mtData),
    .busy(busy), .done(done), .divByZero(divByZero),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural definitions.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
    logic [63:0] p;
    logic sgn;
    sgn = 1'b0;
`ifdef MULT_DIV_SIGNED_EN
    sgn = o[1];
`endif
    edz = 1'b0;
    if (!o[0]) begin
      if (sgn) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else     p = {32'b0, a} * {32'b0, b};
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 0) begin
      eh = a; el = '1; edz = 1'b1;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        el = 32'h8000_0000; eh = '0;
      end else begin
        el = $signed(a) / $signed(b);
        eh = $signed(a) % $signed(b);
      end
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks begin and end just after a falling edge.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit mt_run, input bit start_run, input bit mt_with_start);
    logic [W-1:0] eh, el;
    logic edz;
    int busy_cnt, done_cnt;
    model(o, a, b, eh, el, edz);
    exp_q.push_back(eh);
    exp_q.push_back(el);
    exp_q.push_back({31'b0, edz});
    start = 1'b1; op = o; operandA = a; operandB = b;
    mtWrite = mt_with_start; mtSel = 1'($urandom_range(0, 1)); mtData = $urandom;
    @(posedge clk); #1;
    start = 1'b0; mtWrite = 1'b0;
    operandA = $urandom; operandB = $urandom; op = 2'($urandom_range(0, 3));
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (i == 0 || i == 6 || i == W - 1) begin
        check("hold_hi", hi, cur_hi);
        check("hold_lo", lo, cur_lo);
      end
      start = 1'b0; mtWrite = 1'b0;
      if (start_run && i == 10) begin
        start = 1'b1; op = 2'b01; operandA = $urandom; operandB = $urandom;
      end
      if (mt_run && i == 5) begin
        mtWrite = 1'b1; mtSel = 1'($urandom_range(0, 1)); mtData = $urandom;
      end
    end
    start = 1'b0; mtWrite = 1'b0;
    @(negedge clk);
    check("busy_cycles", busy_cnt, W);
    check("no_early_done", done_cnt, 0);
    check("done", done, 1);
    check("busy_after", busy, 0);
    check("hi", hi, exp_q.pop_front());
    check("lo", lo, exp_q.pop_front());
    check("divByZero", divByZero, exp_q.pop_front());
    cur_hi = eh;
    cur_lo = el;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("done_single", done, 0);
    check("dz_low", divByZero, 0);
  endtask

  task automatic mt_write(input logic sel, input logic [W-1:0] d);
    mtWrite = 1'b1; mtSel = sel; mtData = d;
    @(posedge clk); #1;
    mtWrite = 1'b0;
    if (sel) cur_hi = d; else cur_lo = d;
    @(negedge clk);
    check("mt_hi", hi, cur_hi);
    check("mt_lo", lo, cur_lo);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_seen;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = '0; operandA = '0; operandB = '0;
    mtWrite = 1'b0; mtSel = 1'b0; mtData = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", divByZero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    idle_cycle();
    run_op(2'b01, 32'd100, 32'd7, 0, 1, 0);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);
    idle_cycle();
    run_op(2'b01, 32'h0000_1234, 32'h0, 0, 0, 0);
    check("dz_hi", hi, 32'h0000_1234);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    idle_cycle();
    mt_write(1'b1, 32'hA5A5_A5A5);
    mt_write(1'b0, 32'h5A5A_5A5A);
    run_op(2'b00, 32'd12345, 32'd678, 1, 0, 0);
    idle_cycle();
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 1);
`ifdef MULT_DIV_SIGNED_EN
    check("div_s_lo", lo, 32'hFFFF_FFFD);
    check("div_s_hi", hi, 32'hFFFF_FFFF);
`endif
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
`ifdef MULT_DIV_SIGNED_EN
    check("mult_s_hi", hi, 32'hFFFF_FFFF);
    check("mult_s_lo", lo, 32'hFFFF_FFF1);
`endif
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'b11, 32'h8000_0000, 32'h0, 0, 0, 0);
    run_op(2'b01, 32'h0000_0005, 32'hFFFF_FFFF, 0, 0, 0);
    idle_cycle();

    // Randomized operations, some back-to-back out of DONE
    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = ra;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    // Asynchronous reset during a MULTU
    start = 1'b1; op = 2'b00; operandA = 32'hDEAD_BEEF; operandB = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_done", done, 0);
    cur_hi = '0; cur_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("no_done_after_rst", done_seen, 0);
    run_op(2'b01, 32'd1000, 32'd33, 0, 0, 0);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
